pc: RTL and testbench



---
 rtl/pc_if.sv | 24 ++
 rtl/pc.sv | 37 +++
 tb/tb_pc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Program-counter bundle: control-side load/increment strobes and target, PC value back to fetch.
// Purely combinational wiring with no flow control; the control unit owns every strobe.
interface pc_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             inc;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] o;

  modport master (
    output en,
    output inc,
    output d,
    input  o
  );

  modport slave (
    input  en,
    input  inc,
    input  d,
    output o
  );
endinterface

// File: rtl/pc.sv
// Program counter: one register, updated with priority reset > load > increment > hold; 1-cycle latency.
// No backpressure: a strobe present at a rising edge always takes effect on that edge.
module pc #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Load beats increment, so a taken branch is captured un-incremented; the sum wraps modulo 2^WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (bus.en) begin
      pc_d = bus.d;
    end else if (bus.inc) begin
      pc_d = pc_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.o = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: reset, increment, load, priority, wrap and asynchronous mid-count reset.
module tb_pc;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_if #(.WIDTH(16)) pc_bus ();

  pc #(
    .WIDTH       (16),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pc_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    rst        = 1'b0;
    pc_bus.en  = 1'b1;
    pc_bus.inc = 1'b1;
    pc_bus.d   = 16'h1234;
    #3;
    check("rst_async", pc_bus.o, 16'h0000);
    tick();
    check("rst_hold_edge", pc_bus.o, 16'h0000);

    rst        = 1'b1;
    pc_bus.en  = 1'b0;
    pc_bus.inc = 1'b1;
    tick();
    check("inc_first", pc_bus.o, 16'h0001);

    pc_bus.inc = 1'b0;
    tick();
    check("hold", pc_bus.o, 16'h0001);

    pc_bus.en = 1'b1;
    pc_bus.d  = 16'h00FF;
    tick();
    check("load_00ff", pc_bus.o, 16'h00FF);

    pc_bus.en  = 1'b0;
    pc_bus.inc = 1'b1;
    tick();
    check("inc_carry", pc_bus.o, 16'h0100);

    pc_bus.en  = 1'b1;
    pc_bus.inc = 1'b1;
    pc_bus.d   = 16'h4000;
    tick();
    check("load_priority", pc_bus.o, 16'h4000);

    pc_bus.inc = 1'b0;
    pc_bus.d   = 16'hFFFF;
    tick();
    check("load_ffff", pc_bus.o, 16'hFFFF);

    pc_bus.en  = 1'b0;
    pc_bus.inc = 1'b1;
    tick();
    check("wrap", pc_bus.o, 16'h0000);

    for (int i = 1; i <= 3; i++) begin
      tick();
      check("inc_run", pc_bus.o, 16'(i));
    end

    pc_bus.inc = 1'b0;
    pc_bus.d   = 16'hABCD;
    tick();
    check("d_ignored", pc_bus.o, 16'h0003);

    pc_bus.en = 1'b1;
    pc_bus.d  = 16'h0100;
    tick();
    pc_bus.en  = 1'b0;
    pc_bus.inc = 1'b1;
    tick();
    check("pre_reset_0101", pc_bus.o, 16'h0101);

    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_count", pc_bus.o, 16'h0000);

    pc_bus.en  = 1'bx;
    pc_bus.inc = 1'bx;
    tick();
    check("rst_x_strobes", pc_bus.o, 16'h0000);

    pc_bus.en  = 1'b0;
    pc_bus.inc = 1'b1;
    rst        = 1'b1;
    tick();
    check("post_reset_inc", pc_bus.o, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
